uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised oversampling UART receiver, successor to the fixed 8-bit, bit-clocked receive path. It recovers frames from the asynchronous serial line using an OS_RATE× sample tick, with centre-of-bit sampling and false-start rejection. It supports configurable data width, runtime even/odd parity, one or two stop bits, and parity, framing and overrun error reporting. It sits between the line pins and the UART register/host interface, and delivers words over a valid/ready handshake.

## Interface
- DATA_W, 8, data bits per frame, legal 5..9
- OS_RATE, 16, os_tick pulses per bit period, even, legal 8..32
- FIFO_DEPTH, 4, receive FIFO entries, power of two ≥2; used only with UART_RX_FIFO_EN
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- os_tick  in  1  one-cycle strobe at OS_RATE×baud
- RX_IN  in  1  serial line, idles high, asynchronous
- PAR_EN  in  1  parity bit present and checked
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  two stop bits expected
- P_DATA_OUT  out  DATA_W  received word, LSB first on the line
- DATA_VALID  out  1  word available
- DATA_READY  in  1  consumer accepts when DATA_VALID && DATA_READY
- PAR_ERR  out  1  parity mismatch for the word currently presented
- FRM_ERR  out  1  a stop bit sampled low for the word currently presented
- OVR_ERR  out  1  one-cycle pulse when a completed frame is dropped
- BUSY  out  1  high from start-edge detection until return to IDLE

## Operation
- RX_IN passes through a 2-flop synchroniser that resets to 1. All logic below uses the synchronised line.
- Tick counter tcnt, width clog2(OS_RATE), advances only on os_tick.
- The FSM is registered. States and transitions:
  - IDLE → START on a high-to-low line edge. Clear tcnt. Latch PAR_EN, PAR_TYP and STOP2 into frame registers; changes to these inputs mid-frame are ignored.
  - START: at tick tcnt == OS_RATE/2-1, sample the line.
    - Low: clear tcnt, go to DATA.
    - High: false start, go to IDLE with no output and no error.
  - DATA: sample one bit each time tcnt == OS_RATE-1 (bit centre) and shift it in LSB first. After DATA_W bits, go to PARITY if the latched PAR_EN is set, otherwise to STOP.
  - PARITY: sample the bit. par_err = (^data ^ bit) != latched PAR_TYP.
  - STOP: sample one stop bit, or two if STOP2 is latched. frm_err = OR of the stop samples being low. After the final stop sample, push {frm_err, par_err, data} to the output buffer and go to IDLE.
  - If frm_err is set, go to WAIT_HI instead of IDLE. WAIT_HI → IDLE once the line is high, so a held-low line (break) yields exactly one frame.
- Output buffer: entries are DATA_W+2 bits wide. The head entry drives P_DATA_OUT, PAR_ERR and FRM_ERR, qualified by DATA_VALID.
  - A word is popped on DATA_VALID && DATA_READY.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Push while full: the new frame is dropped, stored contents are untouched, and OVR_ERR pulses for 1 cycle.
- Reset outputs: P_DATA_OUT = 0, DATA_VALID = 0, PAR_ERR = 0, FRM_ERR = 0, OVR_ERR = 0, BUSY = 0. FSM is in IDLE, buffer is empty, synchroniser holds 1s.
- Reset mid-frame aborts the frame with no output. Reception re-arms only on a new falling edge after reset is released.

## Timing
- Edge detection happens 2 clk after an RX_IN change, due to the synchroniser.
- DATA_VALID rises the clk after the os_tick carrying the final stop sample, provided the buffer was empty.
- Frame duration from the start edge is (1 + DATA_W + PAR_EN + 1 + STOP2 − 0.5) bit periods.
- DATA_VALID, P_DATA_OUT, PAR_ERR and FRM_ERR are registered and remain stable while DATA_VALID && !DATA_READY.
- An os_tick is consumed only in non-IDLE states. os_tick held high every clk is legal and is used for simulation speed-up.

## Configuration
- UART_RX_FIFO_EN defined: the output buffer is a FIFO_DEPTH-entry circular FIFO, and overrun occurs only when FIFO_DEPTH words are pending.
- UART_RX_FIFO_EN undefined: the output buffer is a single holding register, equivalent to depth 1, and FIFO_DEPTH is ignored. Overrun occurs when a frame completes while DATA_VALID is high and DATA_READY is low in that cycle.
- The handshake and error behaviour are otherwise identical in both builds.

## Structure
- Package uart_pkg holds:
  - the rx_state_e enum: IDLE, START, DATA, PARITY, STOP, WAIT_HI
  - the rx_word_t struct template: frm_err, par_err, data
  - the PAR_EVEN/PAR_ODD constants
- Sub-module uart_rx_fifo: parametrised width and depth, with push, pop, full and empty. It is instantiated only under UART_RX_FIFO_EN.

## Test plan
All scenarios use DATA_W=8 and OS_RATE=16.

- Send 0xA5, PAR_EN=0, STOP2=0, DATA_READY=1 → one DATA_VALID pulse with P_DATA_OUT=0xA5, PAR_ERR=0, FRM_ERR=0.
- Send 0x3C, PAR_EN=1, PAR_TYP=0, with the parity bit driven to 1 (wrong) → P_DATA_OUT=0x3C with PAR_ERR=1. Repeat with PAR_TYP=1 → PAR_ERR=0.
- Send 0x81 with the stop bit driven low and the line then held low for 3 frames → exactly one word, 0x81 with FRM_ERR=1; no further words until the line returns high.
- Pulse RX_IN low for 4 os_ticks → BUSY pulses, no DATA_VALID, no error flags.
- Hold DATA_READY=0 and send 5 frames 0x01..0x05 with the FIFO build (depth 4) → 0x01..0x04 retained, OVR_ERR pulses once. Release ready → words drain in order. In the non-FIFO build, send 2 frames → only 0x01 is retained.
- Assert reset during data bit 4 of 0x5A → all outputs 0 next clk and no word delivered; a following 0x77 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the oversampling UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_e;

  localparam int MAX_DATA_W = 9;

  typedef struct packed {
    logic                  frm_err;
    logic                  par_err;
    logic [MAX_DATA_W-1:0] data;
  } rx_word_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // ones_odd is the XOR of the data bits and the received parity bit
  function automatic logic par_mismatch(input logic ones_odd, input logic par_typ);
    return (par_typ == PAR_EVEN) ? ones_odd : !ones_odd;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - received-word handshake between the receiver and its consumer
interface uart_rx_os_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] P_DATA_OUT;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic              PAR_ERR;
  logic              FRM_ERR;

  modport master (output P_DATA_OUT, DATA_VALID, PAR_ERR, FRM_ERR, input DATA_READY);
  modport slave  (input P_DATA_OUT, DATA_VALID, PAR_ERR, FRM_ERR, output DATA_READY);

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular receive FIFO; a push while full is accepted only alongside a pop
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with parity/framing/overrun reporting
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OS_RATE    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        os_tick,
  input  logic        RX_IN,
  input  logic        PAR_EN,
  input  logic        PAR_TYP,
  input  logic        STOP2,
  uart_rx_os_if.master rx_if,
  output logic        OVR_ERR,
  output logic        BUSY
);

  localparam int TW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_W);
  localparam int EW = DATA_W + 2;
  localparam logic [TW-1:0] T_MID = TW'(OS_RATE/2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OS_RATE - 1);

  logic [1:0]        r_sync;
  logic              r_rx_q;
  rx_state_e         r_state, w_next;
  logic [TW-1:0]     r_tcnt;
  logic [BW-1:0]     r_bcnt;
  logic              r_scnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en, r_par_typ, r_stop2;
  logic              r_par_err, r_frm_err;
  logic              r_ovr;
  logic              w_rx, w_fall, w_tick_mid, w_tick_end, w_frm_now, w_push, w_pop;
  logic [EW-1:0]     w_entry, w_head;
  logic              w_valid;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_q && !w_rx;
  assign w_tick_mid = os_tick && (r_tcnt == T_MID);
  assign w_tick_end = os_tick && (r_tcnt == T_END);
  assign w_frm_now  = r_frm_err || !w_rx;
  assign w_entry    = {w_frm_now, r_par_err, r_shift};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 2'b11;
      r_rx_q <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], RX_IN};
      r_rx_q <= w_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START:   if (w_tick_mid) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_tick_end && (r_bcnt == BW'(DATA_W-1))) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_tick_end) w_next = STOP;
      STOP: begin
        if (w_tick_end && (r_scnt == r_stop2)) begin
          w_push = 1'b1;
          // a low stop bit may be a break; wait for idle so it yields one frame only
          w_next = w_frm_now ? WAIT_HI : IDLE;
        end
      end
      WAIT_HI: if (w_rx) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_scnt    <= 1'b0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_stop2   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_fall) begin
        r_tcnt    <= '0;
        r_bcnt    <= '0;
        r_scnt    <= 1'b0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_stop2   <= STOP2;
      end else if (os_tick && r_state != IDLE && r_state != WAIT_HI) begin
        r_tcnt <= ((r_state == START) ? w_tick_mid : w_tick_end) ? '0 : r_tcnt + 1'b1;
      end
      if (w_tick_end) begin
        case (r_state)
          DATA: begin
            r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            r_bcnt  <= r_bcnt + 1'b1;
          end
          PARITY: r_par_err <= par_mismatch(^r_shift ^ w_rx, r_par_typ);
          STOP: begin
            r_frm_err <= w_frm_now;
            r_scnt    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  logic          w_full, w_empty;
  logic [EW-1:0] w_rdata;

  assign w_pop   = !w_empty && rx_if.DATA_READY;
  assign w_valid = !w_empty;
  assign w_head  = w_empty ? '0 : w_rdata;

  uart_rx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_entry),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_ovr <= 1'b0;
    else        r_ovr <= w_push && w_full && !w_pop;
  end
`else
  logic          r_valid;
  logic [EW-1:0] r_hold;

  assign w_pop   = r_valid && rx_if.DATA_READY;
  assign w_valid = r_valid;
  assign w_head  = r_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_hold  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_push) begin
        if (!r_valid || w_pop) begin
          r_hold  <= w_entry;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end
`endif

  assign rx_if.P_DATA_OUT = w_head[DATA_W-1:0];
  assign rx_if.PAR_ERR    = w_head[DATA_W];
  assign rx_if.FRM_ERR    = w_head[DATA_W+1];
  assign rx_if.DATA_VALID = w_valid;
  assign OVR_ERR          = r_ovr;
  assign BUSY             = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os (DATA_W=8, OS_RATE=16)
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int OSR = 16;

  logic clk, reset, os_tick, RX_IN, PAR_EN, PAR_TYP, STOP2, OVR_ERR, BUSY;
  int   tick_div = 1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ovr_cnt  = 0;
  bit   busy_seen = 0;
  rx_word_t got_q[$];

  uart_rx_os_if #(.DATA_W(DW)) rx_if();

  uart_rx_os #(.DATA_W(DW), .OS_RATE(OSR), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .os_tick (os_tick),
    .RX_IN   (RX_IN),
    .PAR_EN  (PAR_EN),
    .PAR_TYP (PAR_TYP),
    .STOP2   (STOP2),
    .rx_if   (rx_if),
    .OVR_ERR (OVR_ERR),
    .BUSY    (BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_div == 1) os_tick = 1'b1;
      else               os_tick = ~os_tick;
    end
  end

  always @(negedge clk) begin
    rx_word_t w;
    if (rx_if.DATA_VALID && rx_if.DATA_READY) begin
      w.frm_err = rx_if.FRM_ERR;
      w.par_err = rx_if.PAR_ERR;
      w.data    = {1'b0, rx_if.P_DATA_OUT};
      got_q.push_back(w);
    end
    if (OVR_ERR) ovr_cnt++;
    if (BUSY) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    ovr_cnt   = 0;
    busy_seen = 1'b0;
  endtask

  function automatic rx_word_t word_at(input int i);
    rx_word_t w;
    w = '1;
    if (i < got_q.size()) w = got_q[i];
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pbit,
                            input bit stop_v, input bit idle_v);
    int bc;
    bc = OSR * tick_div;
    RX_IN = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (bc) @(negedge clk);
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (bc) @(negedge clk);
    end
    for (int s = 0; s < (STOP2 ? 2 : 1); s++) begin
      RX_IN = stop_v;
      repeat (bc) @(negedge clk);
    end
    RX_IN = idle_v;
    repeat (bc) @(negedge clk);
  endtask

  initial begin
    rx_word_t w;
    logic [7:0] d;
    int n_frames, exp_words;

    reset = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = PAR_EVEN;
    STOP2 = 1'b0;
    rx_if.DATA_READY = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", rx_if.DATA_VALID, 0);
    check("rst_data",  rx_if.P_DATA_OUT, 0);
    check("rst_par",   rx_if.PAR_ERR, 0);
    check("rst_frm",   rx_if.FRM_ERR, 0);
    check("rst_ovr",   OVR_ERR, 0);
    check("rst_busy",  BUSY, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 with a tick every other clock
    clear_mon();
    tick_div = 2;
    send_frame(8'hA5, 0, 0, 1, 1);
    tick_div = 1;
    repeat (20) @(negedge clk);
    w = word_at(0);
    check("a5_count", got_q.size(), 1);
    check("a5_data",  w.data, 9'h0A5);
    check("a5_par",   w.par_err, 0);
    check("a5_frm",   w.frm_err, 0);
    check("a5_busy",  BUSY, 0);

    clear_mon();
    STOP2 = 1'b1;
    send_frame(8'hC3, 0, 0, 1, 1);
    STOP2 = 1'b0;
    repeat (10) @(negedge clk);
    w = word_at(0);
    check("stop2_count", got_q.size(), 1);
    check("stop2_data",  w.data, 9'h0C3);
    check("stop2_frm",   w.frm_err, 0);

    // 0x3C has four ones: parity bit 1 is wrong for even, right for odd
    clear_mon();
    PAR_EN = 1'b1;
    PAR_TYP = PAR_EVEN;
    send_frame(8'h3C, 1, 1, 1, 1);
    PAR_TYP = PAR_ODD;
    send_frame(8'h3C, 1, 1, 1, 1);
    PAR_EN = 1'b0;
    repeat (10) @(negedge clk);
    check("par_count", got_q.size(), 2);
    w = word_at(0);
    check("par_even_data", w.data, 9'h03C);
    check("par_even_err",  w.par_err, 1);
    w = word_at(1);
    check("par_odd_data",  w.data, 9'h03C);
    check("par_odd_err",   w.par_err, 0);

    // break: stop bit low and line held low for three more frames
    clear_mon();
    send_frame(8'h81, 0, 0, 0, 0);
    repeat (3 * 10 * OSR) @(negedge clk);
    check("brk_busy_hold", BUSY, 1);
    check("brk_count_hold", got_q.size(), 1);
    RX_IN = 1'b1;
    repeat (40) @(negedge clk);
    w = word_at(0);
    check("brk_count", got_q.size(), 1);
    check("brk_data",  w.data, 9'h081);
    check("brk_frm",   w.frm_err, 1);
    check("brk_par",   w.par_err, 0);
    check("brk_busy",  BUSY, 0);

    // false start: 4-tick low glitch
    clear_mon();
    RX_IN = 1'b0;
    repeat (4) @(negedge clk);
    RX_IN = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy",  busy_seen, 1);
    check("glitch_count", got_q.size(), 0);
    check("glitch_ovr",   ovr_cnt, 0);
    check("glitch_idle",  BUSY, 0);

    // overrun with the consumer stalled
`ifdef UART_RX_FIFO_EN
    n_frames = 5;
    exp_words = 4;
`else
    n_frames = 2;
    exp_words = 1;
`endif
    clear_mon();
    rx_if.DATA_READY = 1'b0;
    for (int i = 1; i <= n_frames; i++) begin
      d = 8'(i);
      send_frame(d, 0, 0, 1, 1);
    end
    repeat (5) @(negedge clk);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_valid",  rx_if.DATA_VALID, 1);
    check("ovr_head",   rx_if.P_DATA_OUT, 8'h01);
    check("ovr_none",   got_q.size(), 0);
    rx_if.DATA_READY = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_count", got_q.size(), exp_words);
    for (int i = 0; i < exp_words; i++) begin
      w = word_at(i);
      check("drain_data", w.data, 9'(i + 1));
    end
    check("drain_valid", rx_if.DATA_VALID, 0);

    // reset in the middle of data bit 4 of 0x5A
    clear_mon();
    d = 8'h5A;
    RX_IN = 1'b0;
    repeat (OSR) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      repeat (OSR) @(negedge clk);
    end
    RX_IN = d[4];
    repeat (OSR / 2) @(negedge clk);
    check("mid_busy", BUSY, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", rx_if.DATA_VALID, 0);
    check("mid_rst_data",  rx_if.P_DATA_OUT, 0);
    check("mid_rst_busy",  BUSY, 0);
    check("mid_rst_frm",   rx_if.FRM_ERR, 0);
    check("mid_rst_par",   rx_if.PAR_ERR, 0);
    check("mid_rst_ovr",   OVR_ERR, 0);
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_no_word", got_q.size(), 0);
    send_frame(8'h77, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    w = word_at(0);
    check("post_count", got_q.size(), 1);
    check("post_data",  w.data, 9'h077);
    check("post_frm",   w.frm_err, 0);
    check("post_par",   w.par_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
